dsram_like_bridge: RTL
======================

Name:
dsram_like_bridge

Overview:
- Responder for the EX-stage data-SRAM request port (en / 4-bit wen / addr / wdata).
- Turns each one-cycle request into one transaction on the sram-like data bus (req/addr_ok, data_ok) toward the cache/AXI adapter.
- Holds the pipeline with a stall request until the bus completes, then presents load data to MEM.
- One outstanding transaction at a time.

Parameters:
- ADDR_W, 32: width of data_sram_addr and data_addr.

Ports:
- clk  in  1  rising-edge clock
- resetn  in  1  asynchronous, active-low reset
- data_sram_en  in  1  request valid from EX
- data_sram_wen  in  4  byte write enables; 0000 means load
- data_sram_addr  in  ADDR_W  byte address
- data_sram_wdata  in  32  store data, already lane-replicated
- data_sram_rdata  out  32  load data returned to MEM
- stallreq_for_mem  out  1  pipeline hold request
- data_req  out  1  bus request valid
- data_wr  out  1  1 = store
- data_size  out  2  0 = byte, 1 = half, 2 = word
- data_addr  out  ADDR_W  bus address
- data_wdata  out  32  bus store data
- data_wstrb  out  4  bus byte strobes
- data_addr_ok  in  1  request accepted (valid only while data_req = 1)
- data_data_ok  in  1  response done; data_rdata valid
- data_rdata  in  32  bus load data

Behaviour:
- Reset (async, resetn = 0):
  - State IDLE.
  - All outputs 0; data_sram_rdata = 0.
  - Captured request registers cleared.
  - Reset mid-transaction abandons the transaction; no completion is reported.
- States and transitions:
  - IDLE: if data_sram_en = 1, capture wen/addr/wdata and go to REQ. stallreq_for_mem = data_sram_en (combinational, same cycle).
  - REQ: data_req = 1 with the captured fields held stable. On data_addr_ok go to WAIT. stall = 1.
  - WAIT: data_req = 0. On data_data_ok, register data_rdata into data_sram_rdata (loads only) and go to DONE. stall = 1.
  - DONE: stall = 0 for exactly one cycle; the pipeline advances. data_sram_en is ignored in this cycle (it is the stale request). Go to IDLE.
- Field derivation:
  - data_wr = |wen.
  - data_wstrb = wen.
  - data_size from wen: 1111→2; 0011 or 1100→1; one-hot→0; any other nonzero pattern→2.
  - For loads, size is taken from a mem_size hint of 0; loads always issue data_size = 2 and MEM extracts the bytes.
- Timing:
  - Minimum latency: en in cycle 0 → REQ in cycle 1 (addr_ok = 1) → WAIT in cycle 2 (data_ok = 1) → DONE in cycle 3.
  - data_data_ok asserted while in REQ is ignored.
  - data_addr_ok asserted outside REQ is ignored.
- data_sram_rdata holds its value until the next load completes; stores do not modify it.
- Stores do not wait on data contents, but they still wait for data_ok (write response) before DONE.

Optional Feature:
- Macro DSRAM_KSEG_MAP_EN.
  - Defined: addresses 0x8000_0000–0xBFFF_FFFF map to data_addr = {3'b000, addr[28:0]}; all other addresses pass through unchanged.
  - Undefined: data_addr = captured addr unchanged.
  - Mapping is applied at capture, so it adds no latency.

Decomposition:
- Shared defines header: state encodings (DS_IDLE, DS_REQ, DS_WAIT, DS_DONE), size codes (SIZE_B = 0, SIZE_H = 1, SIZE_W = 2), and the existing Stop / NoStop values for the stall.
- One sub-module is natural: wen_to_size (4-bit wen → 2-bit size), a pure combinational decoder.
- FSM and capture registers stay in the top module.

Test Plan:
- Word load, 0x0000_1004, addr_ok and data_ok each one cycle after the request:
  - data_req = 1 in cycle 1; data_addr = 0x1004, data_wr = 0, data_size = 2.
  - stall = 1 in cycles 0–2, 0 in cycle 3.
  - data_sram_rdata = 0xDEAD_BEEF in cycle 3.
- Byte store, wen = 0100, addr 0x2002, wdata 0x5A5A_5A5A:
  - data_wr = 1, data_size = 0, data_wstrb = 0100, data_wdata = 0x5A5A_5A5A.
  - data_sram_rdata keeps its previous value.
- addr_ok delayed 3 cycles, data_ok delayed 2 further cycles:
  - data_req stays high with fields stable for 4 cycles.
  - stall stays high for 7 cycles total, then exactly one low cycle.
- data_sram_en held high through DONE:
  - No second bus request is issued from the DONE cycle.
  - A new request is issued only if en = 1 in the following IDLE cycle.
- resetn pulsed low while in WAIT:
  - All outputs 0 immediately (async).
  - A late data_ok after release is ignored; the bridge remains in IDLE.
- With DSRAM_KSEG_MAP_EN defined:
  - Load at 0xBFC0_0010 → data_addr = 0x1FC0_0010.
  - Load at 0x0040_0000 → data_addr = 0x0040_0000.

Source files
------------

// File: rtl/dsram_like_bridge_pkg.sv
// Shared encodings for the data-SRAM to sram-like bus bridge: FSM states,
// bus size codes and pipeline stall values.
package dsram_like_bridge_pkg;

   typedef enum logic [1:0] {
      DS_IDLE = 2'd0,
      DS_REQ  = 2'd1,
      DS_WAIT = 2'd2,
      DS_DONE = 2'd3
   } ds_state_e;

   localparam logic [1:0] SIZE_B = 2'd0;
   localparam logic [1:0] SIZE_H = 2'd1;
   localparam logic [1:0] SIZE_W = 2'd2;

   localparam logic STOP    = 1'b1;
   localparam logic NO_STOP = 1'b0;

endpackage

// File: rtl/dsram_like_bridge_if.sv
// sram-like data bus between the bridge (master) and the cache/AXI adapter (slave).
interface dsram_like_bridge_if #(
   parameter int ADDR_W = 32
);
   logic              data_req;
   logic              data_wr;
   logic [1:0]        data_size;
   logic [ADDR_W-1:0] data_addr;
   logic [31:0]       data_wdata;
   logic [3:0]        data_wstrb;
   logic              data_addr_ok;
   logic              data_data_ok;
   logic [31:0]       data_rdata;

   modport master (
      output data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
      input  data_addr_ok, data_data_ok, data_rdata
   );

   modport slave (
      input  data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
      output data_addr_ok, data_data_ok, data_rdata
   );
endinterface

// File: rtl/dsram_like_bridge_wen_to_size.sv
// Byte-enable to bus size decoder; loads (wen = 0) and irregular masks issue a word.
module dsram_like_bridge_wen_to_size
   import dsram_like_bridge_pkg::*;
(
   input  logic [3:0] wen,
   output logic [1:0] size
);
   always_comb begin
      size = SIZE_W;
      case (wen)
         4'b0001, 4'b0010, 4'b0100, 4'b1000: size = SIZE_B;
         4'b0011, 4'b1100:                   size = SIZE_H;
         default:                            size = SIZE_W;
      endcase
   end
endmodule

// File: rtl/dsram_like_bridge.sv
// EX-stage data-SRAM port to sram-like bus bridge, one outstanding transaction.
// Optional DSRAM_KSEG_MAP_EN folds 0x8000_0000-0xBFFF_FFFF to physical at capture.
module dsram_like_bridge
   import dsram_like_bridge_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 data_sram_en,
   input  logic [3:0]           data_sram_wen,
   input  logic [ADDR_W-1:0]    data_sram_addr,
   input  logic [31:0]          data_sram_wdata,
   output logic [31:0]          data_sram_rdata,
   output logic                 stallreq_for_mem,
   dsram_like_bridge_if.master  bus
);
   ds_state_e         state_q, state_d;
   logic [3:0]        wen_q, wen_d;
   logic [1:0]        size_q, size_d, size_dec;
   logic [ADDR_W-1:0] addr_q, addr_d, addr_map;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       rdata_q, rdata_d;

   dsram_like_bridge_wen_to_size u_wen_to_size (
      .wen  (data_sram_wen),
      .size (size_dec)
   );

`ifdef DSRAM_KSEG_MAP_EN
   assign addr_map = (data_sram_addr[ADDR_W-1 -: 2] == 2'b10) ?
                     {3'b000, data_sram_addr[ADDR_W-4:0]} : data_sram_addr;
`else
   assign addr_map = data_sram_addr;
`endif

   always_comb begin
      state_d          = state_q;
      wen_d            = wen_q;
      size_d           = size_q;
      addr_d           = addr_q;
      wdata_d          = wdata_q;
      rdata_d          = rdata_q;
      stallreq_for_mem = NO_STOP;
      case (state_q)
         DS_IDLE: begin
            stallreq_for_mem = data_sram_en ? STOP : NO_STOP;
            if (data_sram_en) begin
               wen_d   = data_sram_wen;
               size_d  = size_dec;
               addr_d  = addr_map;
               wdata_d = data_sram_wdata;
               state_d = DS_REQ;
            end
         end
         DS_REQ: begin
            stallreq_for_mem = STOP;
            if (bus.data_addr_ok) state_d = DS_WAIT;
         end
         DS_WAIT: begin
            stallreq_for_mem = STOP;
            if (bus.data_data_ok) begin
               if (wen_q == 4'b0000) rdata_d = bus.data_rdata;
               state_d = DS_DONE;
            end
         end
         // En is still high here from the request just served; do not re-issue it.
         DS_DONE: state_d = DS_IDLE;
         default: state_d = DS_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= DS_IDLE;
         wen_q   <= '0;
         size_q  <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         wen_q   <= wen_d;
         size_q  <= size_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   assign bus.data_req   = (state_q == DS_REQ);
   assign bus.data_wr    = |wen_q;
   assign bus.data_size  = size_q;
   assign bus.data_addr  = addr_q;
   assign bus.data_wdata = wdata_q;
   assign bus.data_wstrb = wen_q;
   assign data_sram_rdata = rdata_q;
endmodule
